// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for MIPS DIV/DIVU: quotient -> lo_entrance, remainder -> hi_entrance.
// Optional build macro DIV_FAST_SMALL_EN: finish in one iteration when |dividend| < |divisor|.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] regA_out,
  input  logic [WIDTH-1:0] regB_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_entrance,
  output logic [WIDTH-1:0] lo_entrance
);

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifdef DIV_FAST_SMALL_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] rem_r, rem_s, quo_r, quo_s, dvs_r, dvs_s;
  logic [WIDTH-1:0] hi_r, hi_s, lo_r, lo_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             neg_q_r, neg_q_s, neg_r_r, neg_r_s;
  logic             busy_r, busy_s, done_r, done_s, dz_r, dz_s;

  logic             sign_a_s, sign_b_s, small_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]   shift_s, diff_s;

  // Operand magnitudes and the trial subtraction of one iteration (sign = diff_s[WIDTH])
  assign sign_a_s = signed_op & regA_out[WIDTH-1];
  assign sign_b_s = signed_op & regB_out[WIDTH-1];
  assign mag_a_s  = sign_a_s ? negate(regA_out) : regA_out;
  assign mag_b_s  = sign_b_s ? negate(regB_out) : regB_out;
  assign small_s  = FAST_EN && (mag_a_s < mag_b_s);
  assign shift_s  = {rem_r, quo_r[WIDTH-1]};
  assign diff_s   = shift_s - {1'b0, dvs_r};

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      rem_r   <= ZERO_W;
      quo_r   <= ZERO_W;
      dvs_r   <= ZERO_W;
      hi_r    <= ZERO_W;
      lo_r    <= ZERO_W;
      cnt_r   <= CNT_ZERO;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      quo_r   <= quo_s;
      dvs_r   <= dvs_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      cnt_r   <= cnt_s;
      neg_q_r <= neg_q_s;
      neg_r_r <= neg_r_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      dz_r    <= dz_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!start) begin
          state_s = IDLE;
        end else if (regB_out == ZERO_W || small_s) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and next output values; outputs leave through registers
  always_comb begin
    rem_s   = rem_r;
    quo_s   = quo_r;
    dvs_s   = dvs_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    cnt_s   = cnt_r;
    neg_q_s = neg_q_r;
    neg_r_s = neg_r_r;
    dz_s    = dz_r;
    done_s  = 1'b0;
    busy_s  = (state_s != IDLE);
    case (state_r)
      IDLE: begin
        if (start) begin
          dvs_s   = mag_b_s;
          cnt_s   = CNT_ZERO;
          dz_s    = 1'b0;
          neg_q_s = sign_a_s ^ sign_b_s;
          neg_r_s = sign_a_s;
          if (regB_out == ZERO_W) begin
            // Divide by zero reports the raw dividend and an all-ones quotient, unsigned
            quo_s   = ONES_W;
            rem_s   = regA_out;
            neg_q_s = 1'b0;
            neg_r_s = 1'b0;
          end else if (small_s) begin
            quo_s = ZERO_W;
            rem_s = mag_a_s;
          end else begin
            quo_s = mag_a_s;
            rem_s = ZERO_W;
          end
        end else begin
          rem_s = rem_r;
        end
      end
      RUN: begin
        cnt_s = cnt_r + CNT_ONE;
        if (diff_s[WIDTH]) begin
          rem_s = shift_s[WIDTH-1:0];
          quo_s = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
          rem_s = diff_s[WIDTH-1:0];
          quo_s = {quo_r[WIDTH-2:0], 1'b1};
        end
      end
      FIX: begin
        lo_s   = neg_q_r ? negate(quo_r) : quo_r;
        hi_s   = neg_r_r ? negate(rem_r) : rem_r;
        dz_s   = (dvs_r == ZERO_W);
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_zero    = dz_r;
  assign hi_entrance = hi_r;
  assign lo_entrance = lo_r;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: a driver pushes expected results, a monitor checks each done pulse.
module tb_div_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] regA_out = 32'd0;
  logic [31:0] regB_out = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] hi_entrance, lo_entrance;

`ifdef DIV_FAST_SMALL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .signed_op(signed_op),
    .regA_out(regA_out), .regB_out(regB_out), .busy(busy), .done(done),
    .div_zero(div_zero), .hi_entrance(hi_entrance), .lo_entrance(lo_entrance)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc = 0;
  logic        prev_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain 64-bit arithmetic (truncating division, remainder follows dividend)
  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input int unsigned sc);
    exp_t   e;
    longint sa, sbv, q, r, ma, mb;
    int unsigned lat;
    if (b == 32'd0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; lat = 1;
    end else begin
      if (s) begin
        sa = longint'($signed(a)); sbv = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a}); sbv = longint'({32'd0, b});
      end
      q = sa / sbv;
      r = sa % sbv;
      e.lo = q[31:0]; e.hi = r[31:0]; e.dz = 1'b0;
      ma = (sa < 0) ? -sa : sa;
      mb = (sbv < 0) ? -sbv : sbv;
      lat = (FAST && ma < mb) ? 1 : 33;
    end
    e.due = sc + lat;
    return e;
  endfunction

  // Call in the low phase; operation is accepted at the next rising edge
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; signed_op = s; regA_out = a; regB_out = b;
    @(posedge clock);
    #1;
    sb.push_back(model(s, a, b, cyc));
    start = 1'b0;
    regA_out = $urandom; regB_out = $urandom; signed_op = $urandom_range(0, 1);
    chk("busy_after_start", busy, 1'b1);
    chk("dz_cleared_on_start", div_zero, 1'b0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) return;
    end
    checks++;
    $display("FAIL done_timeout: no done within 60 cycles (t=%0t)", $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (done) begin
      chk("done_one_cycle", prev_done, 1'b0);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("lo", lo_entrance, mon_e.lo);
        chk("hi", hi_entrance, mon_e.hi);
        chk("div_zero", div_zero, mon_e.dz);
        chk("latency_cycle", cyc, mon_e.due);
        chk("busy_at_done", busy, 1'b0);
      end
    end
    prev_done <= done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t ea, eb;
    logic [31:0] a, b;
    logic        s;
    #1 reset = 1'b1;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", div_zero, 1'b0);
    chk("rst_hi", hi_entrance, 32'd0);
    chk("rst_lo", lo_entrance, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    @(negedge clock);
    launch(1'b0, 32'd100, 32'd7);              wait_done();
    @(negedge clock);
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);        wait_done();
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);        wait_done();
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    launch(1'b0, 32'hFFFF_FFFF, 32'd1);        wait_done();
    launch(1'b0, 32'h0000_1234, 32'd0);        wait_done();
    launch(1'b1, 32'hFFFF_FFF0, 32'd0);        wait_done();
    launch(1'b0, 32'd3, 32'd10);               wait_done();
    launch(1'b1, 32'hFFFF_FFFD, 32'd10);       wait_done();

    // Results hold while idle
    ea = model(1'b1, 32'hFFFF_FFFD, 32'd10, 0);
    repeat (7) @(negedge clock);
    chk("idle_hold_lo", lo_entrance, ea.lo);
    chk("idle_hold_hi", hi_entrance, ea.hi);

    // start re-pulsed mid-operation is ignored
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    repeat (4) @(negedge clock);
    start = 1'b1; signed_op = 1'b0; regA_out = 32'd55; regB_out = 32'd3;
    @(negedge clock);
    start = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of an operation
    @(negedge clock);
    launch(1'b0, 32'd1000, 32'd7);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_hi", hi_entrance, 32'd0);
    chk("midrst_lo", lo_entrance, 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    launch(1'b0, 32'd9, 32'd3);                wait_done();

    // Back-to-back: second start during the done cycle
    @(negedge clock);
    ea = model(1'b0, 32'd1000, 32'd13, 0);
    launch(1'b0, 32'd1000, 32'd13);            wait_done();
    launch(1'b1, 32'hFFFF_FF00, 32'd7);
    repeat (3) @(negedge clock);
    chk("b2b_hold_lo", lo_entrance, ea.lo);
    chk("b2b_hold_hi", hi_entrance, ea.hi);
    wait_done();

    // Randomized operations, some back-to-back, some with idle gaps
    for (int i = 0; i < 50; i++) begin
      s = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
      launch(s, a, b);
      wait_done();
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
